// File: rtl/sim_sweep_sequencer_pkg.sv
// Shared state encoding and default dimensions for the game-loop sweep sequencer.
package sim_params_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    SWEEP  = 2'b10,
    PAUSED = 2'b11
  } sweep_state_t;

  localparam int GRID_W_DEF   = 160;
  localparam int GRID_H_DEF   = 120;
  localparam int X_BITS_DEF   = 8;
  localparam int Y_BITS_DEF   = 7;
  localparam int LANES_DEF    = 1;
  localparam int DIV_BITS_DEF = 26;
  localparam int FRAME_BITS   = 16;

endpackage

// File: rtl/sim_sweep_sequencer_if.sv
// Beat handshake between the sweep sequencer (master) and the environment writer (slave).
interface sim_sweep_sequencer_if #(
  parameter int LANES  = 1,
  parameter int X_BITS = 8,
  parameter int Y_BITS = 7
) ();
  logic                          wr_valid;
  logic                          wr_ready;
  logic [LANES-1:0][X_BITS-1:0]  wr_x;
  logic [Y_BITS-1:0]             wr_y;
  logic [LANES-1:0]              lane_valid;

  modport master (output wr_valid, output wr_x, output wr_y, output lane_valid, input wr_ready);
  modport slave  (input wr_valid, input wr_x, input wr_y, input lane_valid, output wr_ready);
endinterface

// File: rtl/sim_sweep_sequencer_tick.sv
// Game-tick prescaler: one-cycle tick every max(factor,1) enabled cycles; count cleared while disabled.
module tick_prescaler #(
  parameter int DIV_BITS = 26
) (
  input  logic                clk,
  input  logic                RESET_SIM_N,
  input  logic                en,
  input  logic [DIV_BITS-1:0] factor,
  output logic                tick
);
  logic [DIV_BITS-1:0] count_q, count_d, term;
  logic                tick_q, tick_d;

  assign term = (factor == '0) ? '0 : factor - DIV_BITS'(1);

  always_comb begin
    count_d = '0;
    tick_d  = 1'b0;
    if (en) begin
      // >= rather than == so a factor lowered below the running count still wraps
      if (count_q >= term) tick_d = 1'b1;
      else                 count_d = count_q + DIV_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/sim_sweep_sequencer.sv
// Game-loop sequencer: prescaled tick, full-grid sweep over a valid/ready writer, pause/step/stop, frame count.
// Build option SWEEP_OVERRUN_EN adds overrun_count, a saturating count of ticks dropped during a sweep.
module sim_sweep_sequencer
  import sim_params_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int X_BITS   = X_BITS_DEF,
  parameter int Y_BITS   = Y_BITS_DEF,
  parameter int LANES    = LANES_DEF,
  parameter int DIV_BITS = DIV_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  RESET_SIM_N,
  input  logic                  run,
  input  logic                  pause,
  input  logic                  step,
  input  logic [DIV_BITS-1:0]   factor,
  sim_sweep_sequencer_if.master wr_if,
  output logic                  hold_locs,
  output logic                  game_tick,
  output logic                  sweep_done,
  output logic [FRAME_BITS-1:0] frame_count,
  output logic [1:0]            state_o
`ifdef SWEEP_OVERRUN_EN
  ,
  output logic [15:0]           overrun_count
`endif
);
  // state  | meaning
  // IDLE   | simulation disabled, prescaler cleared
  // RUN    | prescaler counting, waiting for a game tick
  // SWEEP  | issuing beats; never aborted once started
  // PAUSED | frozen at frame boundary; step runs one sweep

  sweep_state_t state_q, state_d;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic step_sweep_q, step_sweep_d;
  logic done_q, done_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic wr_valid_q, wr_valid_d;
  logic [LANES-1:0][X_BITS-1:0] wr_x_q, wr_x_d;
  logic [Y_BITS-1:0] wr_y_q;
  logic [LANES-1:0] lane_valid_q, lane_valid_d;
  logic fire, row_end, last_beat, tick;

  tick_prescaler #(.DIV_BITS(DIV_BITS)) u_tick (
    .clk         (clk),
    .RESET_SIM_N (RESET_SIM_N),
    .en          ((state_q == RUN) || (state_q == SWEEP)),
    .factor      (factor),
    .tick        (tick)
  );

  assign fire      = wr_valid_q && wr_if.wr_ready;
  assign row_end   = (int'(x_q) + LANES) >= GRID_W;
  assign last_beat = row_end && (y_q == Y_BITS'(GRID_H - 1));

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    step_sweep_d = step_sweep_q;
    done_d       = 1'b0;
    frame_d      = frame_q;
    unique case (state_q)
      IDLE: if (run) state_d = RUN;
      RUN: begin
        if (!run)          state_d = IDLE;
        else if (pause)    state_d = PAUSED;
        else if (tick) begin
          state_d      = SWEEP;
          step_sweep_d = 1'b0;
        end
      end
      SWEEP: begin
        if (fire) begin
          if (last_beat) begin
            x_d          = '0;
            y_d          = '0;
            done_d       = 1'b1;
            frame_d      = frame_q + FRAME_BITS'(1);
            step_sweep_d = 1'b0;
            if (!run)                       state_d = IDLE;
            else if (pause || step_sweep_q) state_d = PAUSED;
            else                            state_d = RUN;
          end else if (row_end) begin
            x_d = '0;
            y_d = y_q + Y_BITS'(1);
          end else begin
            x_d = x_q + X_BITS'(LANES);
          end
        end
      end
      PAUSED: begin
        if (!run)       state_d = IDLE;
        else if (step) begin
          state_d      = SWEEP;
          step_sweep_d = 1'b1;
        end
        else if (!pause) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload registers follow the next cursor so the first beat is valid on SWEEP entry
  always_comb begin
    wr_valid_d   = (state_d == SWEEP);
    wr_x_d       = '0;
    lane_valid_d = '0;
    if (wr_valid_d) begin
      for (int i = 0; i < LANES; i++) begin
        wr_x_d[i]       = x_d + X_BITS'(i);
        lane_valid_d[i] = (int'(x_d) + i) < GRID_W;
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      step_sweep_q <= 1'b0;
      done_q       <= 1'b0;
      frame_q      <= '0;
      wr_valid_q   <= 1'b0;
      wr_x_q       <= '0;
      wr_y_q       <= '0;
      lane_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      step_sweep_q <= step_sweep_d;
      done_q       <= done_d;
      frame_q      <= frame_d;
      wr_valid_q   <= wr_valid_d;
      wr_x_q       <= wr_x_d;
      wr_y_q       <= wr_valid_d ? y_d : '0;
      lane_valid_q <= lane_valid_d;
    end
  end

`ifdef SWEEP_OVERRUN_EN
  logic [15:0] overrun_q;

  always_ff @(posedge clk or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N)
      overrun_q <= '0;
    else if ((state_q == SWEEP) && tick && (overrun_q != 16'hFFFF))
      overrun_q <= overrun_q + 16'd1;
  end

  assign overrun_count = overrun_q;
`endif

  assign wr_if.wr_valid   = wr_valid_q;
  assign wr_if.wr_x       = wr_x_q;
  assign wr_if.wr_y       = wr_y_q;
  assign wr_if.lane_valid = lane_valid_q;

  // Gated by reset so every output reads 0 while reset is held
  assign hold_locs   = RESET_SIM_N && !((state_q == SWEEP) && wr_if.wr_ready);
  assign game_tick   = tick;
  assign sweep_done  = done_q;
  assign frame_count = frame_q;
  assign state_o     = state_q;
endmodule
